parallel_port_gpio_v2: RTL and testbench

//  Parametrised bidirectional GPIO port on the Avalon-MM slave bus, successor to the fixed 32-bit expansion PIO.

---
 rtl/parallel_port_gpio_v2.sv | 125 ++++++++++++
 tb/tb_parallel_port_gpio_v2.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_port_gpio_v2.sv
// Avalon-MM GPIO port with per-bit edge capture, atomic set/clear and a post-reset priming window.
// Reads are registered with 1-cycle latency and no wait states; the slave never back-pressures.
module parallel_port_gpio_v2 #(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RISE_RST    = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] FALL_RST    = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  localparam int PRIME_MAX = SYNC_STAGES + 1;
  localparam int PW        = $clog2(PRIME_MAX + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [PW-1:0]    prime_q, prime_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [WIDTH-1:0] pin_s;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] edge_hit;
  logic             wr;
  logic             primed;

  assign pin_s  = sync_q[SYNC_STAGES-1];
  assign wd     = writedata[WIDTH-1:0];
  assign wr     = chipselect & ~write_n;
  assign primed = (prime_q == PW'(PRIME_MAX));

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = dir_q[i] ? data_out_q[i] : 1'bz;
  end

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    w1c        = '0;
    if (wr) begin
      case (address)
        3'd0: data_out_d = wd;
        3'd1: dir_d      = wd;
        3'd2: mask_d     = wd;
        3'd3: w1c        = wd;
        3'd4: data_out_d = data_out_q | wd;
        3'd5: data_out_d = data_out_q & ~wd;
        3'd6: rise_en_d  = wd;
        3'd7: fall_en_d  = wd;
        default: ;
      endcase
    end
  end

  // Edges are judged with the enables held before this cycle's write; a
  // fresh edge beats a same-cycle W1C so no event is ever dropped.
  always_comb begin
    edge_hit  = primed ? ((pin_s & ~prev_q & rise_en_q) | (~pin_s & prev_q & fall_en_q))
                       : '0;
    capture_d = (capture_q & ~w1c) | edge_hit;
    prime_d   = primed ? prime_q : prime_q + PW'(1);
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      3'd0: readdata_d = 32'(pin_s);
      3'd1: readdata_d = 32'(dir_q);
      3'd2: readdata_d = 32'(mask_q);
      3'd3: readdata_d = 32'(capture_q);
      3'd4: readdata_d = 32'(data_out_q);
      3'd5: readdata_d = 32'(data_out_q);
      3'd6: readdata_d = 32'(rise_en_q);
      3'd7: readdata_d = 32'(fall_en_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      prev_q     <= '0;
      data_out_q <= '0;
      dir_q      <= '0;
      mask_q     <= '0;
      capture_q  <= '0;
      rise_en_q  <= RISE_RST;
      fall_en_q  <= FALL_RST;
      prime_q    <= '0;
      readdata_q <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bidir_port};
      prev_q     <= pin_s;
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      capture_q  <= capture_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      prime_q    <= prime_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(capture_q & mask_q);

endmodule

// File: tb/tb_parallel_port_gpio_v2.sv
// Directed bench for parallel_port_gpio_v2: register table plus hand-timed edge, W1C-race and reset sequences.
module tb_parallel_port_gpio_v2;

  localparam int W  = 8;
  localparam int SS = 2;

  localparam logic [1:0] OP_WR  = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_PIN = 2'd2;

  typedef struct {
    logic [1:0]   op;
    logic [2:0]   addr;
    logic         pin_en;
    logic [W-1:0] pin_drv;
    logic [31:0]  data;
    logic [31:0]  exp;
    string        name;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         irq;
  wire  [W-1:0] pins;
  logic [W-1:0] tb_drv;
  logic [W-1:0] tb_en;

  int nvec = 0;
  int nerr = 0;
  vec_t vt[$];

  for (genvar i = 0; i < W; i++) begin : g_drv
    assign pins[i] = tb_en[i] ? tb_drv[i] : 1'bz;
  end

  parallel_port_gpio_v2 #(
    .WIDTH(W), .SYNC_STAGES(SS), .RISE_RST(8'h00), .FALL_RST(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .bidir_port(pins)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic add(input logic [1:0] op, input logic [2:0] a, input logic en,
                     input logic [W-1:0] drv, input logic [31:0] d,
                     input logic [31:0] e, input string nm);
    vec_t v;
    v.op = op; v.addr = a; v.pin_en = en; v.pin_drv = drv;
    v.data = d; v.exp = e; v.name = nm;
    vt.push_back(v);
  endtask

  task automatic pins_set(input logic [W-1:0] v);
    @(negedge clk);
    tb_en = '1; tb_drv = v;
  endtask

  initial begin
    logic [31:0] rd;
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; tb_drv = '0; tb_en = '1;

    // reset values, loop-in with DIR=0, then DATA/OUTSET/OUTCLR composition
    add(OP_RD, 3'd0, 1, 8'h00, 0, 32'h00, "rst_data");
    add(OP_RD, 3'd1, 1, 8'h00, 0, 32'h00, "rst_dir");
    add(OP_RD, 3'd2, 1, 8'h00, 0, 32'h00, "rst_mask");
    add(OP_RD, 3'd3, 1, 8'h00, 0, 32'h00, "rst_capture");
    add(OP_RD, 3'd4, 1, 8'h00, 0, 32'h00, "rst_outset");
    add(OP_RD, 3'd5, 1, 8'h00, 0, 32'h00, "rst_outclr");
    add(OP_RD, 3'd6, 1, 8'h00, 0, 32'h00, "rst_rise_en");
    add(OP_RD, 3'd7, 1, 8'h00, 0, 32'hFF, "rst_fall_en");
    add(OP_RD, 3'd0, 1, 8'h5A, 0, 32'h5A, "pins_z_loopin");
    add(OP_RD, 3'd3, 1, 8'h5A, 0, 32'h00, "rise_disabled");
    add(OP_WR, 3'd0, 1, 8'h5A, 32'hA5, 0, "");
    add(OP_WR, 3'd4, 1, 8'h5A, 32'h0A, 0, "");
    add(OP_WR, 3'd5, 1, 8'h5A, 32'h81, 0, "");
    add(OP_RD, 3'd4, 1, 8'h5A, 0, 32'h2E, "outset_rd");
    add(OP_WR, 3'd1, 0, 8'h00, 32'hFF, 0, "");
    add(OP_WR, 3'd3, 0, 8'h00, 32'hFF, 0, "");
    add(OP_RD, 3'd0, 0, 8'h00, 0, 32'h2E, "data_readback");
    add(OP_RD, 3'd5, 0, 8'h00, 0, 32'h2E, "outclr_rd");
    add(OP_RD, 3'd1, 0, 8'h00, 0, 32'hFF, "dir_rd");
    add(OP_PIN, 3'd0, 0, 8'h00, 0, 32'h2E, "pins_driven");
    add(OP_RD, 3'd3, 0, 8'h00, 0, 32'h00, "cap_w1c_all");

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_irq", {31'b0, irq}, 32'h0);

    for (int i = 0; i < vt.size(); i++) begin
      tb_en  = vt[i].pin_en ? '1 : '0;
      tb_drv = vt[i].pin_drv;
      repeat (3) @(posedge clk);
      case (vt[i].op)
        OP_WR:  bus_write(vt[i].addr, vt[i].data);
        OP_RD: begin
          bus_read(vt[i].addr, rd);
          chk(vt[i].name, rd, vt[i].exp);
        end
        default: begin
          @(negedge clk);
          chk(vt[i].name, 32'(pins), vt[i].exp);
        end
      endcase
    end

    bus_write(3'd1, 32'h00);
    pins_set(8'h00);
    repeat (5) @(posedge clk);
    bus_write(3'd3, 32'hFF);

    // falling-edge capture on bit0 raises irq; W1C drops it next cycle
    bus_write(3'd6, 32'h00);
    bus_write(3'd7, 32'h01);
    bus_write(3'd2, 32'h01);
    pins_set(8'h01);
    repeat (5) @(posedge clk);
    bus_read(3'd3, rd);
    chk("t4_rise_ignored", rd, 32'h00);
    pins_set(8'h00);
    repeat (SS + 2) @(posedge clk);
    bus_read(3'd3, rd);
    chk("t4_fall_cap", rd, 32'h01);
    chk("t4_irq_set", {31'b0, irq}, 32'h1);
    bus_write(3'd3, 32'h01);
    chk("t4_irq_clr", {31'b0, irq}, 32'h0);

    // W1C on bit2 landing on the same edge as a new bit2 fall
    bus_write(3'd7, 32'h04);
    bus_write(3'd2, 32'h04);
    pins_set(8'h04);
    repeat (5) @(posedge clk);
    bus_write(3'd3, 32'hFF);
    pins_set(8'h00);
    repeat (5) @(posedge clk);
    bus_read(3'd3, rd);
    chk("t5_first_cap", rd, 32'h04);
    pins_set(8'h04);
    repeat (5) @(posedge clk);
    @(negedge clk);
    tb_drv = 8'h00;
    repeat (SS) @(negedge clk);
    address = 3'd3; writedata = 32'h04; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    chk("t5_irq_kept", {31'b0, irq}, 32'h1);
    bus_read(3'd3, rd);
    chk("t5_cap_kept", rd, 32'h04);

    // both edges on bit7, then async reset mid-pulse
    bus_write(3'd6, 32'h80);
    bus_write(3'd7, 32'h80);
    bus_write(3'd2, 32'h80);
    repeat (5) @(posedge clk);
    bus_write(3'd3, 32'hFF);
    pins_set(8'h80);
    repeat (10) @(posedge clk);
    bus_read(3'd3, rd);
    chk("t6_rise_cap", rd, 32'h80);
    chk("t6_rise_irq", {31'b0, irq}, 32'h1);
    bus_write(3'd3, 32'h80);
    bus_read(3'd3, rd);
    chk("t6_cleared", rd, 32'h00);
    pins_set(8'h00);
    repeat (10) @(posedge clk);
    bus_read(3'd3, rd);
    chk("t6_fall_cap", rd, 32'h80);
    bus_read(3'd6, rd);
    pins_set(8'h80);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_rd", readdata, 32'h00);
    chk("t6_async_irq", {31'b0, irq}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    bus_read(3'd3, rd);
    chk("t6_no_cap_release", rd, 32'h00);
    bus_read(3'd6, rd);
    chk("t6_rise_en_rst", rd, 32'h00);
    bus_read(3'd0, rd);
    chk("t6_sync_after_rst", rd, 32'h80);

    // pin3 high through reset release: priming must swallow the apparent rise
    pins_set(8'h08);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus_write(3'd6, 32'hFF);
    bus_write(3'd7, 32'h00);
    repeat (5) @(posedge clk);
    bus_read(3'd3, rd);
    chk("t2_primed_no_cap", rd, 32'h00);
    pins_set(8'h00);
    repeat (5) @(posedge clk);
    address = 3'd3;
    @(negedge clk);
    tb_drv = 8'h08;
    repeat (SS + 1) @(negedge clk);
    chk("t2_cap_not_yet", readdata, 32'h00);
    @(negedge clk);
    chk("t2_cap_latency", readdata, 32'h08);
    chk("t2_irq_masked", {31'b0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
